// File: rtl/rvh_noc_local_inject_tx.sv
// Local-port flit injector with per-VC credit counters toward the downstream router.
// Optional sticky overflow flag when RVH_NOC_TX_CRD_OVF_CHECK_EN is defined.
module rvh_noc_local_inject_tx #(
    parameter int VC_NUM   = 4,
    parameter int VC_DEPTH = 2,
    parameter int FLIT_W   = 286,
    localparam int VC_ID_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int CNT_W   = $clog2(VC_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [FLIT_W-1:0]  in_flit,
    input  logic [VC_ID_W-1:0] in_vc_id,
    output logic               tx_flit_v,
    output logic [FLIT_W-1:0]  tx_flit,
    output logic [VC_ID_W-1:0] tx_vc_id,
    input  logic               rx_lcrd_v,
    input  logic [VC_ID_W-1:0] rx_lcrd_id,
    output logic               credits_home,
    output logic               crd_ovf_err
);

    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(VC_DEPTH);

    logic [CNT_W-1:0]   r_crd [VC_NUM];
    logic               r_tx_v;
    logic [FLIT_W-1:0]  r_tx_flit;
    logic [VC_ID_W-1:0] r_tx_id;
    logic               w_in_rdy;
    logic               w_accept;
    logic               w_home;
    logic [VC_NUM-1:0]  w_acc_hit;
    logic [VC_NUM-1:0]  w_ret_hit;

    // Per-VC decode avoids indexing the counter array with an out-of-range id.
    always_comb begin
        w_in_rdy  = 1'b0;
        w_home    = 1'b1;
        w_acc_hit = '0;
        w_ret_hit = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if ((in_vc_id == VC_ID_W'(v)) && (r_crd[v] != '0) && !rst)
                w_in_rdy = 1'b1;
            w_acc_hit[v] = in_vld && !rst && (in_vc_id == VC_ID_W'(v)) && (r_crd[v] != '0);
            w_ret_hit[v] = rx_lcrd_v && (rx_lcrd_id == VC_ID_W'(v));
            if (r_crd[v] != LP_DEPTH)
                w_home = 1'b0;
        end
    end

    assign w_accept     = in_vld && w_in_rdy;
    assign in_rdy       = w_in_rdy;
    assign credits_home = w_home;
    assign tx_flit_v    = r_tx_v;
    assign tx_flit      = r_tx_flit;
    assign tx_vc_id     = r_tx_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_v    <= 1'b0;
            r_tx_flit <= '0;
            r_tx_id   <= '0;
            for (int v = 0; v < VC_NUM; v++)
                r_crd[v] <= LP_DEPTH;
        end else begin
            r_tx_v <= w_accept;
            if (w_accept) begin
                r_tx_flit <= in_flit;
                r_tx_id   <= in_vc_id;
            end
            // Accept and return on the same VC cancel; a return at full saturates.
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_acc_hit[v] && !w_ret_hit[v])
                    r_crd[v] <= r_crd[v] - 1'b1;
                else if (w_ret_hit[v] && !w_acc_hit[v] && (r_crd[v] != LP_DEPTH))
                    r_crd[v] <= r_crd[v] + 1'b1;
            end
        end
    end

`ifdef RVH_NOC_TX_CRD_OVF_CHECK_EN
    localparam logic [VC_ID_W:0] LP_VC_NUM = VC_NUM[VC_ID_W:0];

    logic r_ovf;
    logic w_ovf;

    always_comb begin
        w_ovf = rx_lcrd_v && ({1'b0, rx_lcrd_id} >= LP_VC_NUM);
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_ret_hit[v] && !w_acc_hit[v] && (r_crd[v] == LP_DEPTH))
                w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_ovf)
            r_ovf <= 1'b1;
    end

    assign crd_ovf_err = r_ovf;
`else
    assign crd_ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvh_noc_local_inject_tx.sv
// Randomized + directed bench for rvh_noc_local_inject_tx against a credit-count model.
module tb_rvh_noc_local_inject_tx;

    localparam int FW = 286;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [FW-1:0] in_flit;
    logic [1:0]    in_vc_id;
    logic          tx_flit_v;
    logic [FW-1:0] tx_flit;
    logic [1:0]    tx_vc_id;
    logic          rx_lcrd_v;
    logic [1:0]    rx_lcrd_id;
    logic          credits_home;
    logic          crd_ovf_err;

    // Second instance with 3 VCs so an out-of-range id (3) is expressible.
    logic          in_vld3, in_rdy3, tx_flit_v3, rx_lcrd_v3, credits_home3, crd_ovf_err3;
    logic [7:0]    in_flit3, tx_flit3;
    logic [1:0]    in_vc_id3, tx_vc_id3, rx_lcrd_id3;

    int total = 0;
    int bad = 0;

    int            m_crd [4];
    logic          m_tx_v;
    logic [FW-1:0] m_tx_flit;
    logic [1:0]    m_tx_id;
    logic          m_ovf;

    rvh_noc_local_inject_tx u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_flit(in_flit),
        .in_vc_id(in_vc_id), .tx_flit_v(tx_flit_v), .tx_flit(tx_flit), .tx_vc_id(tx_vc_id),
        .rx_lcrd_v(rx_lcrd_v), .rx_lcrd_id(rx_lcrd_id), .credits_home(credits_home),
        .crd_ovf_err(crd_ovf_err)
    );

    rvh_noc_local_inject_tx #(.VC_NUM(3), .VC_DEPTH(2), .FLIT_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .in_vld(in_vld3), .in_rdy(in_rdy3), .in_flit(in_flit3),
        .in_vc_id(in_vc_id3), .tx_flit_v(tx_flit_v3), .tx_flit(tx_flit3), .tx_vc_id(tx_vc_id3),
        .rx_lcrd_v(rx_lcrd_v3), .rx_lcrd_id(rx_lcrd_id3), .credits_home(credits_home3),
        .crd_ovf_err(crd_ovf_err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_flit();
        logic [FW-1:0] f = '0;
        for (int k = 0; k < 9; k++)
            f = (f << 32) | FW'($urandom);
        return f;
    endfunction

    function automatic logic ovf_enabled();
`ifdef RVH_NOC_TX_CRD_OVF_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic all_home();
        for (int v = 0; v < 4; v++)
            if (m_crd[v] != DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle of stimulus on the main DUT, check it and advance the model.
    task automatic cycle(input logic r, input logic vld, input logic [1:0] id,
                         input logic ret, input logic [1:0] rid);
        logic exp_rdy, acc;
        rst = r; in_vld = vld; in_vc_id = id; in_flit = rand_flit();
        rx_lcrd_v = ret; rx_lcrd_id = rid;
        #1;
        exp_rdy = !r && (m_crd[id] > 0);
        chk("in_rdy", FW'(in_rdy), FW'(exp_rdy));
        chk("credits_home", FW'(credits_home), FW'(all_home()));
        acc = vld && exp_rdy;
        if (r) begin
            for (int v = 0; v < 4; v++) m_crd[v] = DEPTH;
            m_tx_v = 1'b0; m_tx_flit = '0; m_tx_id = '0; m_ovf = 1'b0;
        end else begin
            m_tx_v = acc;
            if (acc) begin
                m_tx_flit = in_flit;
                m_tx_id   = id;
            end
            if (acc && ret && rid == id) begin
                // net zero
            end else begin
                if (acc) m_crd[id] = m_crd[id] - 1;
                if (ret) begin
                    if (m_crd[rid] == DEPTH) m_ovf = ovf_enabled();
                    else m_crd[rid] = m_crd[rid] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("tx_flit_v", FW'(tx_flit_v), FW'(m_tx_v));
        chk("tx_flit", tx_flit, m_tx_flit);
        chk("tx_vc_id", FW'(tx_vc_id), FW'(m_tx_id));
        chk("crd_ovf_err", FW'(crd_ovf_err), FW'(m_ovf));
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_vc_id = '0; in_flit = '0;
        rx_lcrd_v = 1'b0; rx_lcrd_id = '0;
        in_vld3 = 1'b0; in_vc_id3 = '0; in_flit3 = '0; rx_lcrd_v3 = 1'b0; rx_lcrd_id3 = '0;
        for (int v = 0; v < 4; v++) m_crd[v] = DEPTH;
        m_tx_v = 1'b0; m_tx_flit = '0; m_tx_id = '0; m_ovf = 1'b0;
        @(posedge clk); #1;

        // Reset, then three offers on vc 2: two accepts, third refused.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 2, 0, 0);
        cycle(0, 1, 2, 0, 0);
        cycle(0, 1, 2, 0, 0);
        cycle(0, 0, 0, 1, 2);
        cycle(0, 0, 0, 1, 2);

        // vc 1 drained, then offer + return together: refused, credit lands.
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 1);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);

        // vc 0 at 1: accept and return together keep it at 1.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // Accept+return at full on vc 0: net zero, no overflow.
        cycle(0, 1, 0, 1, 0);

        // Return to vc 3 while full: saturate, overflow flag per build.
        cycle(0, 0, 0, 1, 3);
        cycle(0, 0, 0, 0, 0);

        // Accept then reset next cycle.
        cycle(0, 1, 3, 0, 0);
        cycle(1, 1, 3, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Out-of-range VC on the 3-VC instance.
        in_vld3 = 1'b1; in_vc_id3 = 2'd3; in_flit3 = 8'h5a;
        #1;
        chk("oor_in_rdy", FW'(in_rdy3), FW'(1'b0));
        @(posedge clk); #1;
        chk("oor_tx_flit_v", FW'(tx_flit_v3), FW'(1'b0));
        in_vc_id3 = 2'd2;
        #1;
        chk("inrange_in_rdy", FW'(in_rdy3), FW'(1'b1));
        in_vld3 = 1'b0; rx_lcrd_v3 = 1'b1; rx_lcrd_id3 = 2'd3;
        @(posedge clk); #1;
        rx_lcrd_v3 = 1'b0;
        chk("oor_ret_ovf", FW'(crd_ovf_err3), FW'(ovf_enabled()));
        chk("oor_ret_home", FW'(credits_home3), FW'(1'b1));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
